multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/op_classifier.sv | 31 +++
 rtl/multicycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle control sequencer.
//   - state_e      : FSM state encodings (FETCH..HALT)
//   - opcode/funct : instruction field constants recognised by the control
//   - op_class_e   : decoded instruction class produced by op_classifier
package mips_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpcRtype = 6'b000000;
    localparam logic [5:0] OpcJ     = 6'b000010;
    localparam logic [5:0] OpcJal   = 6'b000011;
    localparam logic [5:0] OpcBeq   = 6'b000100;
    localparam logic [5:0] OpcBne   = 6'b000101;
    localparam logic [5:0] OpcBlez  = 6'b000110;
    localparam logic [5:0] OpcBgtz  = 6'b000111;
    localparam logic [5:0] OpcAddi  = 6'b001000;
    localparam logic [5:0] OpcBr9   = 6'b001001;
    localparam logic [5:0] OpcBr10  = 6'b001010;
    localparam logic [5:0] OpcAndi  = 6'b001100;
    localparam logic [5:0] OpcOri   = 6'b001101;
    localparam logic [5:0] OpcLw    = 6'b100011;
    localparam logic [5:0] OpcSw    = 6'b101011;
    localparam logic [5:0] OpcHalt  = 6'b101101;

    localparam logic [5:0] FunctJs  = 6'b001000;

    typedef enum logic [3:0] {
        ClsRtype,
        ClsImm,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJump,
        ClsJal,
        ClsJs,
        ClsHalt,
        ClsIllegal
    } op_class_e;

endpackage

// File: rtl/op_classifier.sv
// op_classifier: purely combinational decode of opcode/funct into an
// instruction class for the sequencer FSM.
// Ports:
//   i_opcode [5:0] : instruction opcode
//   i_funct  [5:0] : function field (only meaningful for R-type)
//   o_class        : decoded class (op_class_e)
module op_classifier
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output op_class_e  o_class
);

    always_comb begin
        o_class = ClsIllegal;
        case (i_opcode)
            // JS lives in the R-type space; every other funct is an ordinary ALU op.
            OpcRtype: o_class = (i_funct == FunctJs) ? ClsJs : ClsRtype;
            OpcAddi, OpcAndi, OpcOri: o_class = ClsImm;
            OpcLw:    o_class = ClsLoad;
            OpcSw:    o_class = ClsStore;
            OpcBeq, OpcBne, OpcBlez, OpcBgtz, OpcBr9, OpcBr10: o_class = ClsBranch;
            OpcJ:     o_class = ClsJump;
            OpcJal:   o_class = ClsJal;
            OpcHalt:  o_class = ClsHalt;
            default:  o_class = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for a multicycle MIPS-like datapath plus
// a retired-instruction counter.
// Ports:
//   Clock, Reset          : rising-edge clock, synchronous active-high reset
//   opcode, funct [5:0]   : instruction fields (IR held from DECODE onward)
//   mem_ready             : completion strobe for the outstanding memory access
//   branch_taken          : ALU compare result, used in EXEC for branches
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite : datapath strobes
//   halted                : high while in HALT
//   illegal               : one-cycle pulse in DECODE on an unsupported opcode
//   state [2:0]           : current state encoding
//   retired [31:0]        : count of completed instructions (wraps)
module multicycle_sequencer
    import mips_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    state_e      r_state;
    logic [31:0] r_retired;

    op_class_e   w_class;
    state_e      w_next;
    logic        w_retire;
    logic        w_pc_write;
    logic        w_ir_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_illegal;

    op_classifier u_op_classifier (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class)
    );

    // Strobes are decoded from the current state and same-cycle inputs so that
    // IRWrite/PCWrite land in the very cycle mem_ready arrives.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            StFetch: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = StDecode;
                end
            end
            StDecode: begin
                case (w_class)
                    ClsHalt: w_next = StHalt;
                    ClsIllegal: begin
                        // Unsupported opcodes retire as a NOP.
                        w_illegal = 1'b1;
                        w_retire  = 1'b1;
                        w_next    = StFetch;
                    end
                    default: w_next = StExec;
                endcase
            end
            StExec: begin
                case (w_class)
                    ClsRtype, ClsImm:  w_next = StWb;
                    ClsLoad, ClsStore: w_next = StMem;
                    ClsBranch: begin
                        w_pc_write = branch_taken;
                        w_retire   = 1'b1;
                        w_next     = StFetch;
                    end
                    ClsJump, ClsJs: begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = StFetch;
                    end
                    ClsJal: begin
                        w_pc_write  = 1'b1;
                        w_reg_write = 1'b1;
                        w_retire    = 1'b1;
                        w_next      = StFetch;
                    end
                    default: w_next = StFetch;
                endcase
            end
            StMem: begin
                if (w_class == ClsLoad) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (w_class == ClsLoad) begin
                        w_next = StWb;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = StFetch;
                    end
                end
            end
            StWb: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = StFetch;
            end
            StHalt: w_next = StHalt;
            default: w_next = StFetch;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= StFetch;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Reset masks every 1-bit output, including the FETCH read request.
    assign PCWrite  = w_pc_write  & ~Reset;
    assign IRWrite  = w_ir_write  & ~Reset;
    assign MemRead  = w_mem_read  & ~Reset;
    assign MemWrite = w_mem_write & ~Reset;
    assign RegWrite = w_reg_write & ~Reset;
    assign illegal  = w_illegal   & ~Reset;
    assign halted   = (r_state == StHalt) & ~Reset;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each directed instruction pushes
// its hand-written per-cycle expected trace; a negedge monitor pops and compares.
module tb_multicycle_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, halted, illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .opcode       (opcode),
        .funct        (funct),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .halted       (halted),
        .illegal      (illegal),
        .state        (state),
        .retired      (retired)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  strb;  // {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, illegal}
        logic        h;
        logic [31:0] ret;
    } rec_t;

    localparam logic [5:0] S0  = 6'b000000;
    localparam logic [5:0] SF  = 6'b101100;  // fetch completes: MemRead+IRWrite+PCWrite
    localparam logic [5:0] SMR = 6'b100000;
    localparam logic [5:0] SMW = 6'b010000;
    localparam logic [5:0] SPC = 6'b000100;
    localparam logic [5:0] SRW = 6'b000010;
    localparam logic [5:0] SPR = 6'b000110;
    localparam logic [5:0] SIL = 6'b000001;

    rec_t        sb[$];
    rec_t        mon_act;
    rec_t        mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic        tracking = 1'b0;
    logic [31:0] exp_ret = 32'd0;
    int          cyc = 0;
    string       tname = "none";

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endfunction

    always @(negedge Clock) begin
        if (tracking) begin
            mon_act = {state, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, illegal,
                       halted, retired};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s c%0d got %h want <empty scoreboard>", tname, cyc, mon_act);
            end else begin
                mon_exp = sb.pop_front();
                check($sformatf("%s c%0d", tname, cyc), 64'(mon_act), 64'(mon_exp));
            end
            cyc++;
        end
    end

    task automatic push(input logic [2:0] st, input logic [5:0] strb, input logic h);
        rec_t r;
        r.st   = st;
        r.strb = strb;
        r.h    = h;
        r.ret  = exp_ret;
        sb.push_back(r);
    endtask

    // Entered and left at posedge+1; mr/rs bit i drives cycle i+1.
    task automatic run(input string name, input int n, input logic [15:0] mr,
                       input logic [15:0] rs);
        tname = name;
        cyc   = 1;
        for (int i = 0; i < n; i++) begin
            mem_ready = mr[i];
            Reset     = rs[i];
            tracking  = 1'b1;
            @(posedge Clock);
            #1;
        end
        tracking  = 1'b0;
        mem_ready = 1'b0;
        Reset     = 1'b0;
    endtask

    task automatic retire_check(input string name);
        exp_ret = exp_ret + 32'd1;
        check({name, " retired"}, 64'(retired), 64'(exp_ret));
        check({name, " state"}, 64'(state), 64'd0);
    endtask

    // Three-cycle control-flow instruction with zero-wait fetch.
    task automatic ctl3(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic bt, input logic [5:0] exec_strb);
        opcode       = op;
        funct        = fn;
        branch_taken = bt;
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, exec_strb, 1'b0);
        run(name, 3, 16'h0007, 16'h0000);
        retire_check(name);
    endtask

    initial begin
        @(posedge Clock);
        #1;
        push(3'd0, S0, 1'b0);
        run("reset", 1, 16'h0000, 16'h0001);
        check("reset state", 64'(state), 64'd0);
        check("reset retired", 64'(retired), 64'd0);

        // add, mem_ready tied high: RegWrite in cycle 4
        opcode = 6'b000000;
        funct  = 6'b100000;
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, S0, 1'b0);
        push(3'd4, SRW, 1'b0);
        run("add", 4, 16'h000F, 16'h0000);
        retire_check("add");

        // ori behaves as an immediate ALU op
        opcode = 6'b001101;
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, S0, 1'b0);
        push(3'd4, SRW, 1'b0);
        run("ori", 4, 16'h000F, 16'h0000);
        retire_check("ori");

        // lw: 2 wait cycles in FETCH, 1 in MEM; mem_ready high in D/E is ignored
        opcode = 6'b100011;
        push(3'd0, SMR, 1'b0);
        push(3'd0, SMR, 1'b0);
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, S0, 1'b0);
        push(3'd3, SMR, 1'b0);
        push(3'd3, SMR, 1'b0);
        push(3'd4, SRW, 1'b0);
        run("lw", 8, 16'h00DC, 16'h0000);
        retire_check("lw");

        ctl3("beq nt", 6'b000100, 6'd0, 1'b0, S0);
        ctl3("beq t", 6'b000100, 6'd0, 1'b1, SPC);
        ctl3("br10 t", 6'b001010, 6'd0, 1'b1, SPC);
        ctl3("j", 6'b000010, 6'd0, 1'b0, SPC);
        ctl3("js", 6'b000000, 6'b001000, 1'b0, SPC);
        ctl3("jal", 6'b000011, 6'd0, 1'b0, SPR);

        // unsupported opcodes: illegal pulse in DECODE, FETCH again in cycle 3
        opcode = 6'b111111;
        push(3'd0, SF, 1'b0);
        push(3'd1, SIL, 1'b0);
        run("ill 3f", 2, 16'h0003, 16'h0000);
        retire_check("ill 3f");
        opcode = 6'b100000;
        push(3'd0, SF, 1'b0);
        push(3'd1, SIL, 1'b0);
        run("ill 20", 2, 16'h0003, 16'h0000);
        retire_check("ill 20");

        // halt: parks in HALT, counter frozen, mem_ready ignored
        opcode = 6'b101101;
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        for (int i = 0; i < 4; i++) push(3'd5, S0, 1'b1);
        run("halt", 6, 16'h003F, 16'h0000);
        check("halt retired", 64'(retired), 64'(exp_ret));
        push(3'd5, S0, 1'b0);
        run("halt rst", 1, 16'h0001, 16'h0001);
        exp_ret = 32'd0;
        check("halt rst state", 64'(state), 64'd0);
        check("halt rst retired", 64'(retired), 64'd0);

        // counter wrap: preload all-ones, then one sw
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        exp_ret = 32'hFFFF_FFFF;
        check("preload retired", 64'(retired), 64'(exp_ret));
        opcode = 6'b101011;
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, S0, 1'b0);
        push(3'd3, SMW, 1'b0);
        run("sw wrap", 4, 16'h000F, 16'h0000);
        retire_check("sw wrap");

        // Reset during a stalled MEM write: MemWrite masked, then FETCH resumes
        push(3'd0, SF, 1'b0);
        push(3'd1, S0, 1'b0);
        push(3'd2, S0, 1'b0);
        push(3'd3, SMW, 1'b0);
        push(3'd3, S0, 1'b0);
        push(3'd0, SMR, 1'b0);
        run("sw rst", 6, 16'h0007, 16'h0010);
        check("sw rst retired", 64'(retired), 64'd0);
        check("sw rst state", 64'(state), 64'd0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
